sram_stream_reader: RTL

Read-side sequencer on the global buffer SRAM's read port: on a start command, reads a block of consecutive words and streams them to the systolic-array feeder over a valid/ready interface. It hides the SRAM's 1-cycle read latency with a 2-entry output FIFO, so it sustains 1 word/cycle and never loses data under backpressure. It sits between the global buffer SRAM (upstream) and the array input skew/feeder (downstream).

---
 rtl/sram_stream_reader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sram_stream_reader.sv
// Read-side sequencer for the global buffer SRAM: on start, reads a block of
// consecutive words and streams them out through a 2-entry FIFO (valid/ready).
module sram_stream_reader #(
  parameter int WORD_SIZE = 128,
  parameter int ADDR_BITS = 10,
  parameter int LEN_BITS  = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [LEN_BITS-1:0]  length,
  output logic                 busy,
  output logic                 done,
  output logic                 sram_re,
  output logic [ADDR_BITS-1:0] sram_addr,
  input  logic [WORD_SIZE-1:0] sram_do,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 out_last,
  output logic [1:0]           dbg_state,
  output logic [1:0]           dbg_count
);

  // Handshake: a beat transfers on every cycle where out_valid && out_ready;
  // out_data/out_last hold while out_valid=1 and out_ready=0.
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [LEN_BITS-1:0]  LEN_ONE  = 1;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = 1;

  state_t               state;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [LEN_BITS-1:0]  len;
  logic [LEN_BITS-1:0]  issued;
  logic                 pending;
  logic                 pending_last;
  logic                 last_issue;
  logic                 pop;
  logic [2:0]           occupancy;

  logic [WORD_SIZE-1:0] fifo_data [2];
  logic                 fifo_last [2];
  logic                 wr_idx;
  logic                 rd_idx;
  logic [1:0]           count;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = fifo_data[rd_idx];
  assign out_last  = out_valid && fifo_last[rd_idx];

  // Words already held plus the one in flight must leave room after this
  // cycle's pop; counting the pop lets issue resume the cycle ready returns.
  assign occupancy  = {1'b0, count} + {2'b00, pending};
  assign sram_re    = (state == RUN) && (issued < len) &&
                      (occupancy < ({2'b00, pop} + 3'd2));
  assign sram_addr  = rd_ptr;
  assign last_issue = ((issued + LEN_ONE) == len);

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;
  assign dbg_count = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      len          <= '0;
      issued       <= '0;
      pending      <= 1'b0;
      pending_last <= 1'b0;
    end else begin
      pending      <= sram_re;
      pending_last <= sram_re && last_issue;
      case (state)
        IDLE: begin
          if (start) begin
            rd_ptr <= base_addr;
            len    <= length;
            issued <= '0;
            state  <= (length != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (sram_re) begin
            rd_ptr <= rd_ptr + ADDR_ONE;
            issued <= issued + LEN_ONE;
            if (last_issue) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_last) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Two-slot circular FIFO; write and pop may coincide at any occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (pending) begin
        fifo_data[wr_idx] <= sram_do;
        fifo_last[wr_idx] <= pending_last;
        wr_idx            <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
      count <= count + {1'b0, pending} - {1'b0, pop};
    end
  end

endmodule
